load_ext_unit: RTL and testbench
================================

Name: load_ext_unit

Overview:
Load-side counterpart of the store-data extension path. Accepts a load request from the MEM stage and issues a word-aligned read to data memory over a req/ack handshake. Selects the addressed byte or halfword lane, sign- or zero-extends it to 32 bits, and returns a registered result. Also flags misaligned or illegal loads and memory timeouts, so the pipeline can stall on loadReady and trap on error.

Parameters:
TIMEOUT, 16, WAIT cycles without memAck before busErr; 0 disables the timeout.
CNT_W, 5, timeout counter width; must satisfy 2**CNT_W > TIMEOUT.

Ports:
clk  input  1  core clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
loadReq  input  1  load request; accepted only when loadReady=1.
funt3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
addr  input  32  byte address of the load.
loadReady  output  1  high in IDLE only.
memReq  output  1  memory read request, registered.
memAddr  output  32  word-aligned read address {addr[31:2],2'b00}, registered.
memAck  input  1  memory has valid data on memRdata this cycle.
memRdata  input  32  memory read word.
loadValid  output  1  one-cycle pulse when a result or error is presented.
dataExt  output  32  extended load data.
misaligned  output  1  valid with loadValid: misaligned address or illegal funt3.
busErr  output  1  valid with loadValid: memory timeout.

Behaviour:
- States: IDLE, WAIT, DONE. Reset forces IDLE immediately (asynchronous).
- Reset values: memReq=0, memAddr=0, loadValid=0, dataExt=0, misaligned=0, busErr=0, counter=0. loadReady=1 as soon as reset releases the state to IDLE.
- IDLE, loadReq=1: capture funt3 and addr[1:0].
  - If funt3 is illegal (011, 110, 111), or a halfword load has addr[0]=1, or LW has addr[1:0]!=0: go to DONE with misaligned=1 and dataExt=0. No memory access is issued.
  - Otherwise set memReq=1, set memAddr, clear the counter, and go to WAIT.
- WAIT: memReq is held high and memAddr stable until memAck.
  - On memAck: memReq=0. Register dataExt from memRdata and the captured offset and funt3. Go to DONE.
  - If TIMEOUT>0 and the counter reaches TIMEOUT with no memAck: memReq=0, busErr=1, dataExt=0, go to DONE.
  - If memAck and timeout occur in the same cycle, memAck wins.
- DONE: loadValid=1 for exactly this cycle, then go to IDLE.
  - misaligned and busErr clear on the next accepted request.
  - dataExt holds its value until the next completion.
- Lane rules, with off=addr[1:0]:
  - LB/LBU select memRdata[8*off+7:8*off].
  - LH/LHU select memRdata[31:16] when off[1]=1, else [15:0].
  - LB and LH sign-extend from the top bit of the lane; LBU and LHU zero-extend.
  - LW passes the word through unchanged.
- Latency, measured from the accept edge (cycle 0):
  - memReq is high in cycle 1.
  - If memAck arrives in cycle k (k>=1), loadValid is high in cycle k+1 and loadReady returns in cycle k+2.
  - Misaligned path: loadValid in cycle 1.
- memAck outside WAIT is ignored. loadReq while loadReady=0 is ignored; the requester holds it until accepted.
- Reset during WAIT: memReq drops asynchronously and the request is abandoned. The memory side must tolerate this; no loadValid is produced.

Decomposition:
- Shared package holds:
  - funct3 constants LB, LH, LW, LBU, LHU.
  - The state encoding IDLE=2'd0, WAIT=2'd1, DONE=2'd2.
  - A misaligned-check function.
- One combinational sub-module, load_align, takes memRdata, off and funt3 and produces the extended word. It is reusable by any future cache-hit bypass path.

Test Plan:
- LB at addr 0x103, memAck in cycle 1, memRdata=0x80FF1234: dataExt=0xFFFFFF80, loadValid in cycle 2, misaligned=0.
- LBU at addr 0x103 with the same data: dataExt=0x00000080. LHU at addr 0x102: dataExt=0x000080FF. LH at addr 0x100: dataExt=0x00001234.
- LW at addr 0x200, memAck delayed 3 cycles:
  - memReq high in cycles 1-3 with memAddr=0x200.
  - memRdata=0xDEADBEEF gives dataExt=0xDEADBEEF, loadValid in cycle 4.
- LW at addr 0x202, then funt3=011 at addr 0x0: each gives loadValid in cycle 1, misaligned=1, memReq never asserted.
- TIMEOUT=16 with memAck never asserted: busErr=1 and loadValid after 16 WAIT cycles, dataExt=0, memReq low afterwards.
- rst pulsed in the 2nd WAIT cycle: memReq=0 and loadReady=1 right after reset; a late memAck produces no loadValid; the next LB completes normally.

Source files
------------

// File: rtl/load_ext_unit_pkg.sv
// Shared load-type encodings, FSM states and the alignment legality check
// used by the load extension unit.
package load_ext_unit_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Any encoding outside the five load types counts as misaligned, so the
  // pipeline takes one trap path for both cases.
  function automatic logic ld_misaligned(input logic [2:0] f, input logic [1:0] off);
    case (f)
      LB, LBU: ld_misaligned = 1'b0;
      LH, LHU: ld_misaligned = off[0];
      LW:      ld_misaligned = (off != 2'b00);
      default: ld_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_ext_unit_align.sv
// Lane select plus sign/zero extension of a memory word. It is purely
// combinational so a cache-hit bypass can reuse it.
module load_align
  import load_ext_unit_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funt3,
  output logic [31:0] o_ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_off, 3'b000} +: 8];
    w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_funt3)
      LB:      o_ext = {{24{w_byte[7]}}, w_byte};
      LBU:     o_ext = {24'd0, w_byte};
      LH:      o_ext = {{16{w_half[15]}}, w_half};
      LHU:     o_ext = {16'd0, w_half};
      default: o_ext = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_ext_unit.sv
// Load request -> word-aligned memory read -> extended, registered result,
// with misalignment and bus-timeout reporting.
module load_ext_unit
  import load_ext_unit_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        loadReq,
  input  logic [2:0]  funt3,
  input  logic [31:0] addr,
  output logic        loadReady,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memAck,
  input  logic [31:0] memRdata,
  output logic        loadValid,
  output logic [31:0] dataExt,
  output logic        misaligned,
  output logic        busErr
);

  state_t             r_state, w_next;
  logic [2:0]         r_funt3;
  logic [1:0]         r_off;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_mis, w_tmo;
  logic [31:0]        w_ext;

  assign w_mis = ld_misaligned(funt3, addr[1:0]);
  // Fires on the TIMEOUT-th WAIT cycle without an ack (counter starts at 0).
  assign w_tmo = (TIMEOUT > 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

  load_align u_align (
    .i_rdata (memRdata),
    .i_off   (r_off),
    .i_funt3 (r_funt3),
    .o_ext   (w_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (loadReq) w_next = w_mis ? DONE : WAIT;
      WAIT:    if (memAck || w_tmo) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    loadReady = (r_state == IDLE);
    loadValid = (r_state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memReq     <= 1'b0;
      memAddr    <= '0;
      dataExt    <= '0;
      misaligned <= 1'b0;
      busErr     <= 1'b0;
      r_cnt      <= '0;
      r_funt3    <= '0;
      r_off      <= '0;
    end else begin
      case (r_state)
        IDLE: if (loadReq) begin
          r_funt3    <= funt3;
          r_off      <= addr[1:0];
          misaligned <= w_mis;
          busErr     <= 1'b0;
          r_cnt      <= '0;
          if (w_mis) begin
            dataExt <= '0;
          end else begin
            memReq  <= 1'b1;
            memAddr <= {addr[31:2], 2'b00};
          end
        end
        WAIT: begin
          // An ack in the same cycle as the timeout still delivers data.
          if (memAck) begin
            memReq  <= 1'b0;
            dataExt <= w_ext;
          end else if (w_tmo) begin
            memReq  <= 1'b0;
            busErr  <= 1'b1;
            dataExt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_ext_unit.sv
// Randomized and directed load traffic against an arithmetic reference of
// the load rules; cycle positions are counted from the accept edge.
module tb_load_ext_unit;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        loadReq = 1'b0;
  logic [2:0]  funt3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic        loadReady, memReq, loadValid, misaligned, busErr;
  logic [31:0] memAddr, dataExt;
  logic        memAck = 1'b0;
  logic [31:0] memRdata = 32'd0;

  int n_vec = 0;
  int n_err = 0;

  load_ext_unit #(.TIMEOUT(TMO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .loadReq(loadReq), .funt3(funt3), .addr(addr),
    .loadReady(loadReady), .memReq(memReq), .memAddr(memAddr),
    .memAck(memAck), .memRdata(memRdata), .loadValid(loadValid),
    .dataExt(dataExt), .misaligned(misaligned), .busErr(busErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_mis(input logic [2:0] f, input logic [1:0] off);
    int unsigned o;
    o = off;
    if (!(f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5)) return 1'b1;
    if ((f == 3'd1 || f == 3'd5) && (o % 2 != 0)) return 1'b1;
    if (f == 3'd2 && o != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_ext(input logic [2:0] f, input logic [1:0] off,
                                          input logic [31:0] w);
    int unsigned v, o;
    o = off;
    v = w;
    if (f == 3'd0 || f == 3'd4) begin
      v = (v >> (8 * o)) % 256;
      if (f == 3'd0 && v >= 128) v = v + 32'hFFFFFF00;
    end else if (f == 3'd1 || f == 3'd5) begin
      v = (v >> ((o >= 2) ? 16 : 0)) % 65536;
      if (f == 3'd1 && v >= 32768) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  // k = cycle in which memAck is driven (0 = never).
  task automatic run_load(input logic [2:0] f, input logic [31:0] a, input int k,
                          input logic [31:0] rd);
    bit mis, be;
    int vc, n;
    logic [31:0] ed;
    mis = ref_mis(f, a[1:0]);
    if (mis) begin
      vc = 1; ed = 32'd0; be = 1'b0;
    end else if (k >= 1 && k <= TMO) begin
      vc = k + 1; ed = ref_ext(f, a[1:0], rd); be = 1'b0;
    end else begin
      vc = TMO + 1; ed = 32'd0; be = 1'b1;
    end
    n = 0;
    while (!loadReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before", {31'd0, loadReady}, 32'd1);
    funt3 = f; addr = a; loadReq = 1'b1; memRdata = rd;
    @(posedge clk);
    #1;
    loadReq = 1'b0; funt3 = 3'($urandom); addr = $urandom;
    for (int c = 1; c <= vc; c++) begin
      @(negedge clk);
      if (c < vc) begin
        chk("memReq_wait", {31'd0, memReq}, 32'd1);
        chk("memAddr", memAddr, a & 32'hFFFF_FFFC);
        chk("valid_early", {31'd0, loadValid}, 32'd0);
      end else begin
        chk("loadValid", {31'd0, loadValid}, 32'd1);
        chk("dataExt", dataExt, ed);
        chk("misaligned", {31'd0, misaligned}, {31'd0, mis});
        chk("busErr", {31'd0, busErr}, {31'd0, be});
        chk("memReq_done", {31'd0, memReq}, 32'd0);
      end
      memAck = (c == k);
    end
    @(negedge clk);
    memAck = 1'b0;
    chk("ready_after", {31'd0, loadReady}, 32'd1);
    chk("valid_pulse", {31'd0, loadValid}, 32'd0);
    chk("dataExt_hold", dataExt, ed);
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra;
    int          rk;
    repeat (2) @(negedge clk);
    chk("rst_memReq", {31'd0, memReq}, 32'd0);
    chk("rst_memAddr", memAddr, 32'd0);
    chk("rst_valid", {31'd0, loadValid}, 32'd0);
    chk("rst_dataExt", dataExt, 32'd0);
    chk("rst_mis", {31'd0, misaligned}, 32'd0);
    chk("rst_busErr", {31'd0, busErr}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, loadReady}, 32'd1);

    run_load(3'b000, 32'h103, 1, 32'h80FF1234);
    run_load(3'b100, 32'h103, 1, 32'h80FF1234);
    run_load(3'b101, 32'h102, 2, 32'h80FF1234);
    run_load(3'b001, 32'h100, 1, 32'h80FF1234);
    run_load(3'b010, 32'h200, 3, 32'hDEADBEEF);
    run_load(3'b010, 32'h202, 1, 32'h12345678);
    run_load(3'b011, 32'h000, 1, 32'h12345678);
    run_load(3'b010, 32'h300, 0, 32'h55AA55AA);
    run_load(3'b010, 32'h304, TMO, 32'hCAFEF00D);
    run_load(3'b001, 32'h101, 2, 32'hFFFF0000);

    // Reset in the 2nd WAIT cycle abandons the request.
    funt3 = 3'b000; addr = 32'h103; loadReq = 1'b1;
    @(posedge clk);
    #1 loadReq = 1'b0;
    @(negedge clk);
    chk("pre_rst_memReq", {31'd0, memReq}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_memReq", {31'd0, memReq}, 32'd0);
    chk("midrst_ready", {31'd0, loadReady}, 32'd1);
    @(negedge clk);
    rst = 1'b0; memAck = 1'b1;
    @(negedge clk);
    memAck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_ack_valid", {31'd0, loadValid}, 32'd0);
      @(negedge clk);
    end
    run_load(3'b000, 32'h103, 1, 32'h80FF1234);

    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom);
      ra = $urandom;
      rk = $urandom_range(1, TMO + 3);
      run_load(rf, ra, rk, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
